// File: rtl/cmd_write.sv
// cmd_write: serialises one 48-bit SD command frame with on-the-fly CRC7,
// then arms the response receiver and enforces the NCR response timeout.
module cmd_write #(
    parameter int TimeoutTicks = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clk_en_i,
    input  logic        start_tx_i,
    input  logic [5:0]  cmd_index_i,
    input  logic [31:0] cmd_argument_i,
    input  logic        expect_rsp_i,
    input  logic        rsp_receiving_i,
    output logic        busy_o,
    output logic        cmd_o,
    output logic        cmd_en_o,
    output logic        start_listening_o,
    output logic        timeout_o,
    output logic        done_o
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SEND     = 3'd1;
    localparam logic [2:0] TURN     = 3'd2;
    localparam logic [2:0] WAIT_RSP = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;
    localparam logic [6:0] LAST_TICK = 7'(TimeoutTicks - 1);

    logic [2:0]  state;
    logic [5:0]  cnt, idx, idx_sel, arg_sel;
    logic [6:0]  crc, tcnt;
    logic [31:0] arg;
    logic        exp_rsp, listen, frame_bit;

    assign idx_sel = 6'd7 - cnt;
    assign arg_sel = 6'd39 - cnt;

    always_comb
        frame_bit = cnt == 6'd0 ? 1'b0 :
                    cnt == 6'd1 ? 1'b1 :
                    cnt < 6'd8  ? idx[idx_sel[2:0]] :
                    cnt < 6'd40 ? arg[arg_sel[4:0]] :
                    cnt < 6'd47 ? crc[6] : 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            crc     <= '0;
            tcnt    <= '0;
            idx     <= '0;
            arg     <= '0;
            exp_rsp <= 1'b0;
            listen  <= 1'b0;
        end else begin
            listen <= 1'b0;
            case (state)
                IDLE: if (start_tx_i) begin
                    idx     <= cmd_index_i;
                    arg     <= cmd_argument_i;
                    exp_rsp <= expect_rsp_i;
                    cnt     <= '0;
                    crc     <= '0;
                    state   <= SEND;
                end
                SEND: if (clk_en_i) begin
                    cnt <= cnt + 6'd1;
                    // payload bits feed the CRC; during the CRC field it just shifts out
                    crc <= {crc[5:0], 1'b0} ^ ((cnt < 6'd40 && (frame_bit ^ crc[6])) ? 7'h09 : 7'h00);
                    if (cnt == 6'd47) state <= TURN;
                end
                TURN: if (clk_en_i) begin
                    state  <= exp_rsp ? WAIT_RSP : DONE;
                    listen <= exp_rsp;
                    tcnt   <= '0;
                end
                WAIT_RSP:
                    if (rsp_receiving_i) state <= DONE;
                    else if (clk_en_i) begin
                        if (tcnt == LAST_TICK) state <= DONE;
                        else tcnt <= tcnt + 7'd1;
                    end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o            = state != IDLE;
    assign cmd_en_o          = state == SEND;
    assign cmd_o             = state == SEND ? frame_bit : 1'b1;
    assign start_listening_o = listen;
    assign done_o            = state == DONE;
    assign timeout_o         = state == WAIT_RSP && clk_en_i && !rsp_receiving_i && tcnt == LAST_TICK;
endmodule

// File: doc/cmd_write.md
# cmd_write

Transmits one SD command frame on the CMD line and arms response reception. It serialises the 48-bit frame {start 0, transmission 1, index[5:0], argument[31:0], CRC7, end 1} at one bit per SD clock strobe and computes the CRC7 on the fly. After the end bit it releases the line and pulses the listen strobe for the response receiver. It then enforces the NCR response timeout. It sits between the command control/register logic and the response receiver, and drives that receiver's start-listening and timeout inputs.

## Interface
- TimeoutTicks, 64, number of clk_en_i ticks in WAIT_RSP without a start bit before timeout is declared (NCR max); legal range 2..127
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- clk_en_i  in  1  SD clock strobe: one clk_i cycle per SD bit period; all bit-level progress happens only in cycles with clk_en_i=1
- start_tx_i  in  1  request to send a command; sampled in IDLE only
- cmd_index_i  in  6  command index, latched with start_tx_i
- cmd_argument_i  in  32  command argument, latched with start_tx_i
- expect_rsp_i  in  1  1 = response expected, latched with start_tx_i
- rsp_receiving_i  in  1  from response receiver: start bit observed
- busy_o  out  1  high from the cycle after accepted start_tx_i through the DONE cycle
- cmd_o  out  1  serial CMD data; 1 whenever not sending
- cmd_en_o  out  1  CMD output enable (pad drive)
- start_listening_o  out  1  one-cycle pulse that arms the response receiver
- timeout_o  out  1  one-cycle pulse: no response within TimeoutTicks
- done_o  out  1  one-cycle pulse: command phase complete (sent, and responded, timed out or no response expected)

## Operation
- States: IDLE, SEND, TURN, WAIT_RSP, DONE.
- IDLE:
  - start_tx_i=1 latches index, argument and expect_rsp_i, clears bit counter cnt[5:0] and crc[6:0], and moves to SEND.
  - clk_en_i is not required for this transition.
- SEND:
  - cmd_en_o=1; cmd_o = frame bit 47-cnt (MSB first).
  - Frame bits: cnt 0 → 0; cnt 1 → 1; cnt 2..7 → index[5:0]; cnt 8..39 → argument[31:0]; cnt 40..46 → crc[6]; cnt 47 → 1.
  - On each clk_en_i tick, cnt increments.
  - CRC update for cnt 0..39: fb = cmd_o ^ crc[6]; crc = {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00).
  - CRC output for cnt 40..46: crc shifts left, zero fill.
  - A tick at cnt=47 moves to TURN.
- TURN:
  - cmd_en_o=0, cmd_o=1.
  - On a tick: go to WAIT_RSP if the latched expect_rsp=1, otherwise go to DONE.
- WAIT_RSP:
  - start_listening_o=1 in the first clk_i cycle in this state only.
  - Timeout counter tcnt[6:0] is cleared on entry and increments on each tick.
  - rsp_receiving_i=1 → DONE, with no timeout.
  - A tick with tcnt=TimeoutTicks-1 and rsp_receiving_i=0 → timeout_o=1 for that one cycle, then DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- start_tx_i outside IDLE is ignored; latched fields are not modified.
- Simultaneous rsp_receiving_i and final timeout tick: rsp_receiving_i wins, and timeout_o stays 0.

## Timing
- Reset values (asynchronous; take effect immediately, including mid-frame):
  - state IDLE; cmd_o=1; cmd_en_o=0.
  - busy_o, start_listening_o, timeout_o, done_o all 0.
  - cnt, tcnt and crc are 0.
- All outputs are decoded from registered state/counters only, with no combinational path from inputs.
- Exception: timeout_o is qualified by the clk_en_i and rsp_receiving_i of the same cycle.
- Each frame bit is stable from the cycle after the previous tick up to and including its own tick. Bit 0 is driven from the first SEND cycle.
- Frame length is exactly 48 ticks in SEND, then 1 tick in TURN, so the line is released for one bit before listening starts.
- With clk_en_i held at 1:
  - start_tx_i accepted at cycle 0; SEND spans cycles 1–48; TURN is cycle 49.
  - start_listening_o is at cycle 50.
  - With the default timeout and no response, timeout_o is at cycle 113 and done_o at cycle 114.
- clk_en_i low stalls SEND, TURN and WAIT_RSP indefinitely with all outputs held.
- IDLE → SEND and DONE → IDLE transitions ignore clk_en_i.

## Test plan
- CMD0, argument 0, clk_en_i=1: cmd_o over 48 ticks equals 0x40_00000000_95 (CRC 0x4A); cmd_en_o high for exactly those 48 cycles.
- CMD8, argument 0x000001AA: frame 0x48_000001AA_87. CMD17, argument 0: frame 0x51_00000000_55. Both run with clk_en_i asserted every 4th cycle; each bit is held 4 cycles.
- expect_rsp_i=1 and rsp_receiving_i pulsed 5 ticks after start_listening_o: exactly one start_listening_o, then done_o, with no timeout_o.
- No response, TimeoutTicks=64: timeout_o on the 64th WAIT_RSP tick, done_o the next cycle, busy_o falling after done_o. A second run raises rsp_receiving_i on the 64th tick itself: no timeout_o.
- expect_rsp_i=0: no start_listening_o; done_o directly after TURN. start_tx_i pulsed mid-frame with a different index: frame unchanged and no second frame.
- rst_ni asserted at cnt=20: cmd_en_o=0 and cmd_o=1 without waiting for a clock edge. After release, a new CMD0 frame is bit-exact.
